// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: shared press-FSM encoding and 12 MHz default timing for key_longpress_ctrl
package key_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYC = 240000;
  localparam int DEF_LONG_CYC     = 36000000;
  localparam int DEF_REPEAT_CYC   = 2400000;

endpackage

// File: rtl/key_channel.sv
// key_channel: one key: synchroniser, debounce, short/long press FSM, optional auto-repeat (KEY_REPEAT_EN)
module key_channel
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic long_active,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);

  logic          sync1, sync2;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold;
  logic          at_long, short_nxt, long_nxt;
  key_state_e    state, nxt;

  // synchronise the inverted key and accept a level change only after DEBOUNCE_CYC disagreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
      if (sync2 != key_level) begin
        db_cnt    <= (db_cnt == DW'(DEBOUNCE_CYC - 1)) ? '0 : db_cnt + DW'(1);
        key_level <= (db_cnt == DW'(DEBOUNCE_CYC - 1)) ? ~key_level : key_level;
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign at_long = hold == HW'(LONG_CYC - 1);

  // state register, saturating hold counter and registered press outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      long_active <= 1'b0;
    end else begin
      state       <= nxt;
      hold        <= (state != PRESSED) ? '0 : (hold == HW'(LONG_CYC)) ? hold : hold + HW'(1);
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
      long_active <= nxt == LONG;
    end
  end

  // next state; a release always takes priority over reaching the long threshold
  always_comb begin
    nxt = state == IDLE    ? (key_level ? PRESSED : IDLE)
        : state == PRESSED ? (!key_level ? IDLE : at_long ? LONG : PRESSED)
        : state == LONG    ? (key_level ? LONG : IDLE)
        : IDLE;
  end

  // pulse decode, registered above so no path from key_n reaches an output combinationally
  always_comb begin
    short_nxt = (state == PRESSED) && !key_level;
    long_nxt  = (state == PRESSED) && key_level && at_long;
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_hit;

  assign rep_hit = (state == LONG) && key_level && (rep_cnt == RW'(REPEAT_CYC - 1));

  // repeat period counter, running only while the key is held in LONG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= ((state == LONG) && key_level && !rep_hit) ? rep_cnt + RW'(1) : '0;
      repeat_pulse <= rep_hit;
    end
  end
`else
  logic unused_repeat;

  assign unused_repeat = ^REPEAT_CYC;
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: rtl/key_longpress_ctrl.sv
// key_longpress_ctrl: NUM_KEYS independent debounced short/long-press channels; auto-repeat with KEY_REPEAT_EN
module key_longpress_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int NUM_KEYS     = 3,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] short_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] long_active,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n[g]),
      .key_level   (key_level[g]),
      .short_pulse (short_pulse[g]),
      .long_pulse  (long_pulse[g]),
      .long_active (long_active[g]),
      .repeat_pulse(repeat_pulse[g])
    );
  end

endmodule

// File: doc/key_longpress_ctrl.md
# key_longpress_ctrl

Parametrised multi-channel key front end that replaces ad-hoc per-key long-press counters in top-level test wrappers. Each active-low raw key is synchronised and debounced, then classified by a per-channel press FSM as a short press or a long press, with an optional auto-repeat. It sits between the board key pins and game/menu logic such as mode switching, and also drives the LED status indicators. All channels run independently on the 12 MHz system clock.

## Interface
- NUM_KEYS, 3, number of key channels
- DEBOUNCE_CYC, 240000, consecutive stable cycles needed to accept a level change (20 ms at 12 MHz); must be ≥1
- LONG_CYC, 36000000, hold cycles in PRESSED before a long press is declared (3 s); must be ≥2
- REPEAT_CYC, 2400000, auto-repeat period in LONG (200 ms); used only with KEY_REPEAT_EN
- clk  in  1  12 MHz system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- key_n  in  NUM_KEYS  raw keys, active-low, asynchronous to clk
- key_level  out  NUM_KEYS  debounced pressed level, 1 = pressed
- short_pulse  out  NUM_KEYS  one-cycle pulse on release from PRESSED
- long_pulse  out  NUM_KEYS  one-cycle pulse on entry to LONG
- long_active  out  NUM_KEYS  high while the FSM is in LONG
- repeat_pulse  out  NUM_KEYS  one-cycle auto-repeat pulse; constant 0 without KEY_REPEAT_EN

## Operation
- Per channel: 2-flop synchroniser on ~key_n, then a debounce counter. A mismatch between the synchronised input and the debounced state increments the counter. The debounced state flips when the count reaches DEBOUNCE_CYC. Any cycle of agreement clears the counter.
- The FSM is driven by the debounced state (key_level register):
  - IDLE → PRESSED on key_level = 1; hold counter cleared.
  - PRESSED: hold counter increments by 1 per cycle. key_level = 0 → IDLE with short_pulse. Hold counter = LONG_CYC−1 with key_level = 1 → LONG with long_pulse.
  - LONG: long_active = 1. key_level = 0 → IDLE; no short_pulse is issued.
- Release and threshold in the same cycle: release wins. short_pulse is issued and long_pulse is not.
- The hold counter width is $clog2(LONG_CYC+1). It saturates and never wraps.
- A glitch shorter than DEBOUNCE_CYC cycles produces no change on any output.
- Channels are fully independent. Simultaneous presses on all channels are legal.

## Timing
- Reset value of every output is 0. On reset, all FSMs go to IDLE, debounced states go to released, and all counters clear.
- Reset mid-press aborts the press silently. A key still held after rst_n deasserts is treated as a new press after full debounce.
- Press latency: key_level rises DEBOUNCE_CYC+2 clock edges after key_n goes stably low. Release latency is the same.
- short_pulse is high in the cycle after key_level falls.
- long_pulse and long_active rise LONG_CYC+1 cycles after key_level rises. long_active falls the cycle after key_level falls.
- All outputs are registered. No combinational path from key_n to any output.

## Configuration
- KEY_REPEAT_EN defined:
  - A repeat counter runs in LONG only.
  - The first repeat_pulse occurs REPEAT_CYC cycles after long_pulse, then every REPEAT_CYC cycles until release.
  - The counter clears on leaving LONG.
- KEY_REPEAT_EN undefined: no repeat counter is synthesised, repeat_pulse is tied to 0, and REPEAT_CYC is ignored.

## Structure
- Shared package key_ctrl_pkg holds:
  - FSM state encoding: IDLE = 2'd0, PRESSED = 2'd1, LONG = 2'd2.
  - Default timing constants for 12 MHz: 20 ms, 3 s, 200 ms.
- Sub-module key_channel contains one synchroniser, debounce counter, FSM and optional repeat counter. The top instantiates it NUM_KEYS times in a generate loop.

## Test plan
All scenarios use NUM_KEYS=3, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.
- Short press: key_n[0] low for 10 cycles, then high → key_level[0] high at edge 6. short_pulse[0] is a single cycle about 7 cycles after release. long_pulse stays 0.
- Long press: key_n[1] low for 40 cycles → long_pulse[1] fires 21 cycles after key_level[1] rises. long_active[1] holds until 1 cycle after key_level falls. No short_pulse.
- Glitch rejection: key_n[2] low for 3 cycles, high 2, low 3 → all outputs for channel 2 remain 0.
- Release at threshold: release timed so key_level falls in the cycle the hold counter reaches 19 → short_pulse only; no long_pulse.
- Reset mid-press: assert rst_n low during LONG on channel 0 → all outputs 0 immediately. Holding the key after rst_n deasserts gives key_level high after 6 edges.
- KEY_REPEAT_EN: hold 40 cycles → repeat_pulse at +5 and +10 after long_pulse, and so on. Without the macro, repeat_pulse stays 0.
